// File: rtl/fifo_rr_ctrl.sv
// Shared-FIFO controller: round-robin write arbitration across NREQ producers,
// single-consumer reads, registered pointers, occupancy and sticky error flags.
module fifo_rr_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int NREQ  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] wr_req,
  input  logic            rd_req,
  input  logic            clr_err,
  output logic [NREQ-1:0] wr_grant,
  output logic [2:0]      wr_sel,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count,
  output logic            ovf_err,
  output logic            udf_err
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [2:0]  LAST_RST = 3'(NREQ-1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    last_q, last_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic [NREQ-1:0] grant;
  logic [2:0]      sel;
  logic            found;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Two passes give the wrap: indices above last first, then 0..last.
  always_comb begin
    grant = '0;
    sel   = '0;
    found = 1'b0;
    if (!full) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && wr_req[j] && (j > int'(last_q))) begin
          grant[j] = 1'b1;
          sel      = 3'(j);
          found    = 1'b1;
        end
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!found && wr_req[j] && (j <= int'(last_q))) begin
          grant[j] = 1'b1;
          sel      = 3'(j);
          found    = 1'b1;
        end
      end
    end
  end

  assign wr_grant = grant;
  assign wr_sel   = sel;
  assign wr_en    = found;
  assign rd_en    = rd_req & ~empty;
  assign wr_addr  = wr_ptr_q;
  assign rd_addr  = rd_ptr_q;
  assign count    = count_q;
  assign ovf_err  = ovf_q;
  assign udf_err  = udf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      last_d   = sel;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A new error event on the same edge as clr_err keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (full && (|wr_req)) begin
      ovf_d = 1'b1;
    end
    if (empty && rd_req) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= LAST_RST;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Randomised scoreboard bench for fifo_rr_ctrl against an occupancy/round-robin
// reference model; includes power-on and mid-operation asynchronous reset.
module tb_fifo_rr_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int NR    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] wr_req;
  logic          rd_req;
  logic          clr_err;
  logic [NR-1:0] wr_grant;
  logic [2:0]    wr_sel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ovf_err;
  logic          udf_err;

  fifo_rr_ctrl #(.DEPTH(DEPTH), .AW(AW), .NREQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .rd_req(rd_req), .clr_err(clr_err),
    .wr_grant(wr_grant), .wr_sel(wr_sel), .wr_en(wr_en),
    .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .full(full), .empty(empty), .count(count),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int g, s, we, wa, re, ra, f, e, c, ov, ud;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // reference model state
  int      m_cnt, m_wtot, m_rtot, m_last, m_ovf, m_udf;
  bit [NR-1:0] pend;
  int      max_seen;

  task automatic chk(input string n, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wtot = 0; m_rtot = 0;
    m_last = NR - 1; m_ovf = 0; m_udf = 0;
    pend = '0;
  endtask

  // One clock cycle: drive, predict, enqueue, then advance the model.
  task automatic step(input int pw, input int pr, input int pc);
    exp_t e;
    int   idx;
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      if (!pend[i] && ($urandom_range(99) < pw)) pend[i] = 1'b1;
    wr_req  = pend;
    rd_req  = ($urandom_range(99) < pr);
    clr_err = ($urandom_range(99) < pc);
    #1;
    e.f  = (m_cnt == DEPTH);
    e.e  = (m_cnt == 0);
    e.c  = m_cnt;
    e.wa = m_wtot % DEPTH;
    e.ra = m_rtot % DEPTH;
    e.ov = m_ovf;
    e.ud = m_udf;
    e.g  = 0; e.s = 0; e.we = 0;
    if (!e.f) begin
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (e.we == 0 && pend[idx]) begin
          e.g = 1 << idx; e.s = idx; e.we = 1;
        end
      end
    end
    e.re = (rd_req && !e.e) ? 1 : 0;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (e.f && (pend != 0)) m_ovf = 1;
      else if (clr_err) m_ovf = 0;
      if (e.e && rd_req) m_udf = 1;
      else if (clr_err) m_udf = 0;
      m_cnt  = m_cnt + e.we - e.re;
      m_wtot = m_wtot + e.we;
      m_rtot = m_rtot + e.re;
      if (e.we) begin
        m_last = e.s;
        pend[e.s] = 1'b0;
      end
      if (m_cnt > max_seen) max_seen = m_cnt;
    end
  endtask

  // Monitor: compares the DUT against each queued expectation mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        x = q.pop_front();
        chk("wr_grant", int'(wr_grant), x.g);
        chk("wr_en",    int'(wr_en),    x.we);
        if (x.we) chk("wr_sel", int'(wr_sel), x.s);
        chk("wr_addr",  int'(wr_addr),  x.wa);
        chk("rd_en",    int'(rd_en),    x.re);
        chk("rd_addr",  int'(rd_addr),  x.ra);
        chk("full",     int'(full),     x.f);
        chk("empty",    int'(empty),    x.e);
        chk("count",    int'(count),    x.c);
        chk("ovf_err",  int'(ovf_err),  x.ov);
        chk("udf_err",  int'(udf_err),  x.ud);
      end
    end
  end

  initial begin
    int pre_cnt;
    rst_n   = 1'b0;
    wr_req  = '0;
    rd_req  = 1'b0;
    clr_err = 1'b0;
    max_seen = 0;
    model_reset();
    repeat (3) step(0, 0, 0);
    #1 rst_n = 1'b1;
    repeat (3) step(0, 0, 0);
    repeat (300) step(40, 40, 5);
    repeat (150) step(70, 10, 3);
    repeat (150) step(10, 90, 3);
    repeat (200) step(60, 50, 5);
    repeat (100) step(80, 5, 0);
    pre_cnt = m_cnt;
    #2;
    rst_n   = 1'b0;
    wr_req  = '0;
    rd_req  = 1'b0;
    clr_err = 1'b0;
    model_reset();
    repeat (2) step(0, 0, 0);
    #1 rst_n = 1'b1;
    repeat (200) step(50, 50, 5);
    repeat (2) @(negedge clk);
    #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    n_cmp++;
    if (max_seen != DEPTH) begin
      n_fail++;
      $display("FAIL reach_full: max count %0d expected %0d", max_seen, DEPTH);
    end
    if (pre_cnt == 0)
      $display("note: count was 0 before mid-run reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_ctrl.md
Name: fifo_rr_ctrl

Overview:
Shared-FIFO controller for the 8-entry FIFO storage. It arbitrates write requests from NREQ producers with round-robin priority and accepts reads from one consumer. It generates registered-pointer write/read addresses, write/read enables, full/empty flags and an occupancy count. It sits between the producers/consumer and the FIFO RAM, and also drives the RAM write-data mux select.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of two.
AW, 3, address width; log2(DEPTH).
NREQ, 2, number of write requesters (2..8).

Ports:
clk  input  1  clock; all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
wr_req  input  NREQ  per-producer write request; level, held until granted.
rd_req  input  1  consumer read request.
clr_err  input  1  synchronous clear of the sticky error flags.
wr_grant  output  NREQ  one-hot grant, combinational, same cycle as the request.
wr_sel  output  3  binary index of the granted producer; drives the data mux.
wr_en  output  1  RAM write enable; equals |wr_grant.
wr_addr  output  AW  RAM write address; equals the write pointer.
rd_en  output  1  RAM read enable.
rd_addr  output  AW  RAM read address; equals the read pointer.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  AW+1  occupancy, 0..DEPTH.
ovf_err  output  1  sticky: some wr_req was held off because the FIFO was full.
udf_err  output  1  sticky: rd_req was asserted while empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0; count = 0.
  - empty = 1, full = 0.
  - Round-robin pointer last = NREQ-1, so producer 0 has first priority.
  - ovf_err = udf_err = 0.
  - wr_grant = 0, wr_en = 0, rd_en = 0.
  - Reset mid-operation discards all contents; there is no partial-state retention.
- State: wr_ptr[AW-1:0], rd_ptr[AW-1:0], count[AW:0], last[2:0], ovf_err, udf_err. All registered.
- Write arbitration (combinational from registered state):
  - Grant only when !full.
  - Search from index last+1 upward, wrapping modulo NREQ. The first asserted wr_req wins.
  - The winner gets its wr_grant bit set, wr_sel = its index, wr_en = 1.
  - At most one grant per cycle.
  - On a clock edge with wr_en = 1: last <= wr_sel; wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0 naturally.
- Read:
  - rd_en = rd_req & !empty.
  - On an edge with rd_en = 1: rd_ptr <= rd_ptr+1, with wrap.
  - Data appears from the RAM per the RAM's latency; this block only addresses it.
- Count update:
  - +1 on write-only, -1 on read-only.
  - Unchanged when both or neither occur.
  - full and empty are decoded combinationally from the registered count.
- Simultaneous read+write:
  - When full: the write is blocked (full is already 1), the read proceeds, count becomes DEPTH-1. The write is granted the next cycle.
  - When empty: the read is blocked, the write proceeds, count becomes 1.
  - When neither full nor empty: both proceed and count is unchanged.
- Errors:
  - ovf_err <= 1 on an edge where full & |wr_req.
  - udf_err <= 1 on an edge where empty & rd_req.
  - clr_err = 1 clears both flags. If clr_err and a new error event occur on the same edge, the set wins.
- Grant latency: 0 cycles (grant is combinational). The pointer and count effects are visible 1 cycle later.
- Requesters must not deassert wr_req in the cycle they are granted. The write completes on that edge.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, wr_addr=0, rd_addr=0, all grants 0, both error flags 0.
- wr_req=2'b11 held for 4 cycles -> grants alternate 01,10,01,10; wr_addr steps 0,1,2,3; count reaches 4.
- Fill: 8 writes from producer 0 -> full=1 on the cycle after the 8th write, count=8. Hold wr_req=1 one more cycle -> no grant, ovf_err=1. Then rd_req=1 and wr_req=1 together -> rd_en=1, wr_en=0, count=7.
- Wrap: 10 writes interleaved with 10 reads -> wr_addr and rd_addr sequence 0..7,0,1; count never exceeds 1; empty toggles correctly.
- On an empty FIFO, rd_req=1 with wr_req=01 in the same cycle -> rd_en=0, wr_en=1, count=1, udf_err=1. Next cycle clr_err=1 -> udf_err=0.
- With count=5, assert rst_n=0 asynchronously between clock edges -> count=0, empty=1 and pointers 0 immediately, without waiting for a clock edge.
